// File: rtl/bl_sel_decoder_pkg.sv
// bl_pkg: shared types and constants for the bit-line select decoder.
//   state_e - decoder FSM states
//   dly_t   - 4-bit dead-time / settle count
//   ld_val  - converts a cycle count into the down-counter load value
package bl_pkg;
    localparam int BL_WIDTH      = 8;
    localparam int BL_ADDR_WIDTH = 3;
    localparam int DLY_WIDTH     = 4;
    typedef logic [DLY_WIDTH-1:0] dly_t;
    typedef enum logic [1:0] {IDLE, GAP, DRIVE, HOLD} state_e;
    // The state is left on the edge where the count is already zero,
    // so an N-cycle interval loads N-1.
    function automatic dly_t ld_val(int n);
        return (n == 0) ? '0 : dly_t'(n - 1);
    endfunction
endpackage

// File: rtl/bl_sel_decoder_delay_cnt.sv
// bl_delay_cnt: loadable 4-bit down-counter shared by dead time and settling.
//   clk        - clock
//   rst_n_i    - asynchronous active-low reset
//   load_i     - load load_val_i this edge (wins over decrement)
//   load_val_i - value to load
//   zero_o     - count is zero; the counter holds at zero
module bl_delay_cnt
    import bl_pkg::*;
(
    input  logic clk,
    input  logic rst_n_i,
    input  logic load_i,
    input  dly_t load_val_i,
    output logic zero_o
);
    dly_t cnt_q, cnt_d;
    always_comb cnt_d = load_i ? load_val_i : (zero_o ? cnt_q : cnt_q - 1'b1);
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/bl_sel_decoder.sv
// bl_sel_decoder: converts the gated EN + A2..A0 bus into a registered one-hot
// bit-line select with break-before-make dead time and a settle-qualified valid.
//   clk        - clock
//   Reset      - asynchronous active-low reset
//   EN_in      - select enable
//   A2_in..A0_in - bit-line address, MSB first
//   BL_sel     - one-hot bit-line select (registered)
//   sel_addr   - latched address
//   sel_valid  - selected line has driven for SETTLE_CYCLES
//   busy       - in dead time or settling
//   switch_cnt - saturating count of completed selections; present only when
//                BL_SEL_SWITCH_CNT_EN is defined
module bl_sel_decoder
    import bl_pkg::*;
#(
    parameter int GAP_CYCLES    = 1,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     Reset,
    input  logic                     EN_in,
    input  logic                     A2_in,
    input  logic                     A1_in,
    input  logic                     A0_in,
    output logic [BL_WIDTH-1:0]      BL_sel,
    output logic [BL_ADDR_WIDTH-1:0] sel_addr,
    output logic                     sel_valid,
`ifdef BL_SEL_SWITCH_CNT_EN
    output logic                     busy,
    output logic [15:0]              switch_cnt
`else
    output logic                     busy
`endif
);
    localparam dly_t GAP_LD = ld_val(GAP_CYCLES);
    localparam dly_t SET_LD = ld_val(SETTLE_CYCLES);
    state_e                   state_q, state_d;
    logic [BL_ADDR_WIDTH-1:0] addr, addr_q, addr_d;
    logic [BL_WIDTH-1:0]      bl_q, bl_d;
    logic                     valid_q, valid_d, busy_q, busy_d;
    logic                     ld, cnt_zero;
    dly_t                     ld_v;
    assign addr = {A2_in, A1_in, A0_in};
    bl_delay_cnt u_cnt (
        .clk        (clk),
        .rst_n_i    (Reset),
        .load_i     (ld),
        .load_val_i (ld_v),
        .zero_o     (cnt_zero)
    );
    // Disable beats everything; a new or changed address (re)starts the
    // sequence from the dead time, which also covers relatch inside GAP.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ld      = 1'b0;
        ld_v    = GAP_LD;
        if (!EN_in) begin
            state_d = IDLE;
        end else if (state_q == IDLE || addr != addr_q) begin
            addr_d  = addr;
            ld      = 1'b1;
            state_d = (GAP_CYCLES == 0) ? DRIVE : GAP;
            ld_v    = (GAP_CYCLES == 0) ? SET_LD : GAP_LD;
        end else if (state_q == GAP && cnt_zero) begin
            state_d = DRIVE;
            ld      = 1'b1;
            ld_v    = SET_LD;
        end else if (state_q == DRIVE && cnt_zero) begin
            state_d = HOLD;
        end
        // Outputs are decoded from the next state so they register glitch-free
        // and clear on the same edge that leaves DRIVE/HOLD.
        bl_d    = (state_d == DRIVE || state_d == HOLD) ? BL_WIDTH'(1) << addr_d : '0;
        valid_d = (state_d == HOLD);
        busy_d  = (state_d == GAP || state_d == DRIVE);
    end
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            bl_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            bl_q    <= bl_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end
    assign BL_sel    = bl_q;
    assign sel_addr  = addr_q;
    assign sel_valid = valid_q;
    assign busy      = busy_q;
`ifdef BL_SEL_SWITCH_CNT_EN
    logic [15:0] sw_q;
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset)                                                  sw_q <= '0;
        else if (state_q == DRIVE && state_d == HOLD && sw_q != 16'hFFFF) sw_q <= sw_q + 16'd1;
    end
    assign switch_cnt = sw_q;
`endif
endmodule
